// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   In-order retirement buffer. Rename allocates one entry per cycle at the
//   tail, a single writeback port marks entries done, and at most one done
//   entry retires per cycle from the head, returning its superseded PRN to
//   the rename free list.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   alloc_valid       rename presents an instruction
//   alloc_ready       ROB can accept an allocation this cycle
//   alloc_has_dest    instruction writes a register
//   alloc_dest_arch   architectural destination
//   alloc_p_new       PRN newly mapped to the destination
//   alloc_p_old       PRN previously mapped (from the RAT)
//   alloc_idx         index assigned to the allocation (current tail)
//   wb_valid, wb_idx  execution completion of entry wb_idx
//   flush             synchronous discard of all entries
//   commit_valid      head entry retires this cycle
//   commit_has_dest   retiring entry frees a register
//   commit_dest_arch  arch register of the retiring entry
//   commit_p_new      committed mapping
//   commit_p_old      PRN to push onto the free list
//   empty, full       occupancy status
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_ENTRIES = 16,
  parameter int NUM_A_REGS  = 32,
  parameter int NUM_P_REGS  = 48,
  localparam int AW = $clog2(NUM_A_REGS),
  localparam int PW = $clog2(NUM_P_REGS),
  localparam int IW = $clog2(ROB_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  input  logic          alloc_has_dest,
  input  logic [AW-1:0] alloc_dest_arch,
  input  logic [PW-1:0] alloc_p_new,
  input  logic [PW-1:0] alloc_p_old,
  output logic [IW-1:0] alloc_idx,
  input  logic          wb_valid,
  input  logic [IW-1:0] wb_idx,
  input  logic          flush,
  output logic          commit_valid,
  output logic          commit_has_dest,
  output logic [AW-1:0] commit_dest_arch,
  output logic [PW-1:0] commit_p_new,
  output logic [PW-1:0] commit_p_old,
  output logic          empty,
  output logic          full
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int              PTRW    = IW + 1;
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

  logic [PTRW-1:0] head_reg, head_next;
  logic [PTRW-1:0] tail_reg, tail_next;
  logic [PTRW-1:0] count_reg, count_next;

  logic [ROB_ENTRIES-1:0] valid_reg, valid_next;
  logic [ROB_ENTRIES-1:0] done_reg, done_next;

  // Payload storage; only read while the entry is valid, so it needs no reset.
  logic          has_dest_mem  [ROB_ENTRIES];
  logic [AW-1:0] dest_arch_mem [ROB_ENTRIES];
  logic [PW-1:0] p_new_mem     [ROB_ENTRIES];
  logic [PW-1:0] p_old_mem     [ROB_ENTRIES];

  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic          do_alloc;
  logic          do_commit;
  logic          wb_ok;
  logic          alloc_dest_norm;

  assign head_idx = head_reg[IW-1:0];
  assign tail_idx = tail_reg[IW-1:0];

  // ---------------------------------------------------------------- status
  assign full        = (head_idx == tail_idx) && (head_reg[IW] != tail_reg[IW]);
  assign empty       = (head_reg == tail_reg);
  assign alloc_ready = !full && !flush;
  assign alloc_idx   = tail_idx;

  // Flush gates all three events: alloc via alloc_ready, commit via
  // commit_valid, writeback explicitly here.
  assign do_alloc  = alloc_valid && alloc_ready;
  assign do_commit = commit_valid;
  assign wb_ok     = wb_valid && !flush && valid_reg[wb_idx];

  // Writes to arch register 0 are architecturally discarded, so such an
  // entry must never hand a PRN back to the free list.
  assign alloc_dest_norm = alloc_has_dest && (alloc_dest_arch != '0);

  // ---------------------------------------------------------------- commit
  assign commit_valid = valid_reg[head_idx] && done_reg[head_idx] && !flush;

  always_comb begin
    commit_has_dest  = 1'b0;
    commit_dest_arch = '0;
    commit_p_new     = '0;
    commit_p_old     = '0;
    if (commit_valid) begin
      commit_has_dest  = has_dest_mem[head_idx];
      commit_dest_arch = dest_arch_mem[head_idx];
      commit_p_new     = p_new_mem[head_idx];
      commit_p_old     = p_old_mem[head_idx];
    end
  end

  // ---------------------------------------------------------------- pointers
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (do_commit) head_next = head_reg + PTR_ONE;
      if (do_alloc)  tail_next = tail_reg + PTR_ONE;
      case ({do_alloc, do_commit})
        2'b10:   count_next = count_reg + PTR_ONE;
        2'b01:   count_next = count_reg - PTR_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------- entries
  // Alloc and commit never target the same slot in one cycle: the head slot
  // is also the tail slot only when empty (no commit) or full (no alloc).
  // Likewise a writeback cannot hit the slot being allocated, because that
  // slot is invalid and wb_ok filters it out.
  for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_entry
    logic alloc_hit;
    logic commit_hit;
    logic wb_hit;

    assign alloc_hit  = do_alloc  && (tail_idx == IW'(gi));
    assign commit_hit = do_commit && (head_idx == IW'(gi));
    assign wb_hit     = wb_ok     && (wb_idx   == IW'(gi));

    always_comb begin
      valid_next[gi] = valid_reg[gi];
      done_next[gi]  = done_reg[gi];
      if (flush) begin
        valid_next[gi] = 1'b0;
        done_next[gi]  = 1'b0;
      end else if (alloc_hit) begin
        valid_next[gi] = 1'b1;
        done_next[gi]  = 1'b0;
      end else begin
        if (commit_hit) valid_next[gi] = 1'b0;
        if (wb_hit)     done_next[gi]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      done_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      has_dest_mem[tail_idx]  <= alloc_dest_norm;
      dest_arch_mem[tail_idx] <= alloc_dest_arch;
      p_new_mem[tail_idx]     <= alloc_p_new;
      p_old_mem[tail_idx]     <= alloc_dest_norm ? alloc_p_old : '0;
    end
  end

  // The occupancy counter must always agree with the pointer distance.
  count_matches_pointers: assert property (
    @(posedge clk) disable iff (!rst_n) count_reg == PTRW'(tail_reg - head_reg)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed bench for reorder_buffer. A queue-based model of the in-flight
//   program order predicts every output each cycle; a compare process checks
//   the DUT against it on the falling edge. Hand-computed literal checks pin
//   the model at the interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic       alloc_has_dest = 1'b0;
  logic [4:0] alloc_dest_arch = '0;
  logic [5:0] alloc_p_new = '0;
  logic [5:0] alloc_p_old = '0;
  logic [3:0] alloc_idx;
  logic       wb_valid = 1'b0;
  logic [3:0] wb_idx = '0;
  logic       flush = 1'b0;
  logic       commit_valid;
  logic       commit_has_dest;
  logic [4:0] commit_dest_arch;
  logic [5:0] commit_p_new;
  logic [5:0] commit_p_old;
  logic       empty;
  logic       full;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_has_dest   (alloc_has_dest),
    .alloc_dest_arch  (alloc_dest_arch),
    .alloc_p_new      (alloc_p_new),
    .alloc_p_old      (alloc_p_old),
    .alloc_idx        (alloc_idx),
    .wb_valid         (wb_valid),
    .wb_idx           (wb_idx),
    .flush            (flush),
    .commit_valid     (commit_valid),
    .commit_has_dest  (commit_has_dest),
    .commit_dest_arch (commit_dest_arch),
    .commit_p_new     (commit_p_new),
    .commit_p_old     (commit_p_old),
    .empty            (empty),
    .full             (full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  // Program-order queue of in-flight instructions; front is the oldest.
  typedef struct {
    logic [3:0] idx;
    logic       hd;
    logic [4:0] arch;
    logic [5:0] pn;
    logic [5:0] po;
    logic       done;
  } ent_t;

  ent_t mq[$];
  int   tail_m = 0;
  logic [5:0] commit_log[$];

  always @(posedge clk) begin : model_update
    bit   com;
    bit   can_alloc;
    ent_t e;
    if (!rst_n || flush) begin
      mq.delete();
      tail_m = 0;
    end else begin
      com       = (mq.size() > 0) && mq[0].done;
      can_alloc = (mq.size() < 16);
      if (wb_valid)
        foreach (mq[k]) if (mq[k].idx == wb_idx) mq[k].done = 1'b1;
      if (com) void'(mq.pop_front());
      if (alloc_valid && can_alloc) begin
        e.idx  = 4'(tail_m % 16);
        e.hd   = alloc_has_dest && (alloc_dest_arch != 5'd0);
        e.arch = alloc_dest_arch;
        e.pn   = alloc_p_new;
        e.po   = e.hd ? alloc_p_old : 6'd0;
        e.done = 1'b0;
        mq.push_back(e);
        tail_m++;
      end
    end
  end

  // ------------------------------------------------------------ compare
  always @(negedge clk) begin : compare
    int   sz;
    logic exp_cv;
    if (rst_n) begin
      sz     = mq.size();
      exp_cv = (sz > 0) && mq[0].done && !flush;
      chk("empty",       32'(empty),       32'(sz == 0));
      chk("full",        32'(full),        32'(sz == 16));
      chk("alloc_ready", 32'(alloc_ready), 32'((sz < 16) && !flush));
      chk("alloc_idx",   32'(alloc_idx),   32'(tail_m % 16));
      chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
      if (exp_cv) begin
        chk("commit_has_dest",  32'(commit_has_dest),  32'(mq[0].hd));
        chk("commit_dest_arch", 32'(commit_dest_arch), 32'(mq[0].arch));
        chk("commit_p_new",     32'(commit_p_new),     32'(mq[0].pn));
        chk("commit_p_old",     32'(commit_p_old),     32'(mq[0].po));
      end else begin
        chk("commit_has_dest idle",  32'(commit_has_dest),  0);
        chk("commit_dest_arch idle", 32'(commit_dest_arch), 0);
        chk("commit_p_new idle",     32'(commit_p_new),     0);
        chk("commit_p_old idle",     32'(commit_p_old),     0);
      end
      if (commit_valid === 1'b1) begin
        commit_log.push_back(commit_p_old);
        $display("commit: arch=%0d has_dest=%0d p_new=%0d p_old=%0d",
                 commit_dest_arch, commit_has_dest, commit_p_new, commit_p_old);
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_alloc(input logic hd, input logic [4:0] a,
                           input logic [5:0] pn, input logic [5:0] po);
    alloc_valid     = 1'b1;
    alloc_has_dest  = hd;
    alloc_dest_arch = a;
    alloc_p_new     = pn;
    alloc_p_old     = po;
  endtask

  task automatic set_wb(input logic [3:0] i);
    wb_valid = 1'b1;
    wb_idx   = i;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 64; i++) begin
      if (empty === 1'b1) break;
      tick();
    end
    chk(name, 32'(empty), 1);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    // Reset state
    tick();
    tick();
    chk("reset alloc_ready",  32'(alloc_ready),  1);
    chk("reset empty",        32'(empty),        1);
    chk("reset full",         32'(full),         0);
    chk("reset commit_valid", 32'(commit_valid), 0);
    chk("reset alloc_idx",    32'(alloc_idx),    0);
    chk("reset commit_p_old", 32'(commit_p_old), 0);
    rst_n = 1'b1;

    // Out-of-order writeback, in-order commit
    set_alloc(1, 5'd1, 6'd32, 6'd1); #1 chk("t1 alloc_idx 0", 32'(alloc_idx), 0); tick();
    set_alloc(1, 5'd2, 6'd33, 6'd2); #1 chk("t1 alloc_idx 1", 32'(alloc_idx), 1); tick();
    set_alloc(1, 5'd3, 6'd34, 6'd3); #1 chk("t1 alloc_idx 2", 32'(alloc_idx), 2); tick();
    set_wb(4'd2); #1 chk("t1 no commit before head done", 32'(commit_valid), 0); tick();
    set_wb(4'd0); #1 chk("t1 wb head same cycle", 32'(commit_valid), 0); tick();
    set_wb(4'd1);
    #1 chk("t1 commit0 valid", 32'(commit_valid), 1);
    chk("t1 commit0 p_old", 32'(commit_p_old), 1);
    tick();
    #1 chk("t1 commit1 valid", 32'(commit_valid), 1);
    chk("t1 commit1 p_old", 32'(commit_p_old), 2);
    tick();
    #1 chk("t1 commit2 valid", 32'(commit_valid), 1);
    chk("t1 commit2 p_old", 32'(commit_p_old), 3);
    chk("t1 commit2 p_new", 32'(commit_p_new), 34);
    tick();
    #1 chk("t1 empty", 32'(empty), 1);

    // Fill to full (pointers start at 3), refuse 17th, commit+alloc on full
    for (int i = 0; i < 16; i++) begin
      set_alloc(1, 5'(i + 1), 6'(i + 16), 6'(i + 1));
      tick();
    end
    #1 chk("t2 full", 32'(full), 1);
    chk("t2 alloc_ready", 32'(alloc_ready), 0);
    set_alloc(1, 5'd7, 6'd40, 6'd7);
    #1 chk("t2 17th refused", 32'(alloc_ready), 0);
    tick();
    set_wb(4'd3); tick();
    set_alloc(1, 5'd9, 6'd41, 6'd9);
    #1 chk("t6 commit while full", 32'(commit_valid), 1);
    chk("t6 commit p_old", 32'(commit_p_old), 1);
    chk("t6 alloc refused", 32'(alloc_ready), 0);
    tick();
    set_alloc(1, 5'd9, 6'd41, 6'd9);
    #1 chk("t6 alloc_ready after commit", 32'(alloc_ready), 1);
    chk("t6 alloc_idx old head", 32'(alloc_idx), 3);
    tick();
    for (int i = 0; i < 16; i++) begin
      set_wb(4'(4 + i));
      tick();
    end
    wait_empty("t2 drain timeout");

    // Wrap-around stream: 40 allocations, each written back two cycles later
    flush = 1'b1; tick();
    commit_log.delete();
    for (int i = 0; i < 42; i++) begin
      if (i < 40) set_alloc(1, 5'(i % 31 + 1), 6'(i + 8), 6'(i + 1));
      if (i >= 2) set_wb(4'(i - 2));
      if (i < 40) begin
        #1 chk("t3 alloc_idx", 32'(alloc_idx), 32'(i % 16));
      end
      tick();
    end
    wait_empty("t3 drain timeout");
    chk("t3 commit count", 32'(commit_log.size()), 40);
    foreach (commit_log[k]) chk("t3 commit order", 32'(commit_log[k]), 32'(k + 1));

    // Destination arch 0 never frees a PRN (tail is at 8 here)
    set_alloc(1, 5'd0, 6'd20, 6'd5); tick();
    set_wb(4'd8); tick();
    #1 chk("t4 commit_valid", 32'(commit_valid), 1);
    chk("t4 commit_has_dest", 32'(commit_has_dest), 0);
    chk("t4 commit_p_old", 32'(commit_p_old), 0);
    tick();

    // Flush with concurrent writeback and allocation
    flush = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1, 5'(i + 1), 6'(i + 10), 6'(i + 1));
      tick();
    end
    set_wb(4'd1); tick();
    set_wb(4'd0); tick();
    flush = 1'b1;
    set_wb(4'd2);
    set_alloc(1, 5'd6, 6'd15, 6'd6);
    #1 chk("t5 commit suppressed", 32'(commit_valid), 0);
    chk("t5 alloc_ready in flush", 32'(alloc_ready), 0);
    tick();
    set_wb(4'd3);
    #1 chk("t5 empty after flush", 32'(empty), 1);
    chk("t5 alloc_idx after flush", 32'(alloc_idx), 0);
    tick();
    #1 chk("t5 late wb no effect", 32'(empty), 1);
    set_alloc(1, 5'd4, 6'd30, 6'd4); tick();
    #1 chk("t5 new entry not done", 32'(commit_valid), 0);
    set_wb(4'd0); tick();
    #1 chk("t5 new entry commits", 32'(commit_valid), 1);
    chk("t5 new entry p_old", 32'(commit_p_old), 4);
    tick();

    // Asynchronous reset in the middle of a cycle
    set_alloc(1, 5'd2, 6'd21, 6'd2); tick();
    set_alloc(1, 5'd3, 6'd22, 6'd3); tick();
    #2 rst_n = 1'b0;
    #1 chk("t7 async empty", 32'(empty), 1);
    chk("t7 async alloc_idx", 32'(alloc_idx), 0);
    chk("t7 async full", 32'(full), 0);
    chk("t7 async alloc_ready", 32'(alloc_ready), 1);
    tick();
    rst_n = 1'b1;
    #1 chk("t7 empty after release", 32'(empty), 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer at the far end of the rename→commit protocol.
- Accepts one allocation per cycle from rename: arch dest, new PRN, previous PRN.
- Marks entries complete from a single writeback port.
- Retires at most one completed entry per cycle from the head, in program order. Each retirement returns the superseded PRN to the rename free list.

Parameters:
- ROB_ENTRIES, 16, number of entries; power of two.
- NUM_A_REGS, 32, architectural registers; arch index width AW = $clog2(NUM_A_REGS) = 5.
- NUM_P_REGS, 48, physical registers; PRN width PW = $clog2(NUM_P_REGS) = 6.
- IW = $clog2(ROB_ENTRIES) = 4, ROB index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  ROB can accept an allocation this cycle.
- alloc_has_dest  in  1  instruction writes a register.
- alloc_dest_arch  in  AW  architectural destination.
- alloc_p_new  in  PW  PRN newly mapped to the destination.
- alloc_p_old  in  PW  PRN previously mapped (from the RAT).
- alloc_idx  out  IW  index assigned to the allocation (the current tail).
- wb_valid  in  1  execution completion.
- wb_idx  in  IW  completing entry.
- flush  in  1  synchronous discard of all entries.
- commit_valid  out  1  head entry retires this cycle.
- commit_has_dest  out  1  retiring entry frees a register.
- commit_dest_arch  out  AW  arch register of the retiring entry.
- commit_p_new  out  PW  committed mapping.
- commit_p_old  out  PW  PRN to push onto the free list.
- empty  out  1  no valid entries.
- full  out  1  count == ROB_ENTRIES.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset state: head = tail = 0, with a wrap bit each (IW+1 bits); count = 0; all valid/done bits 0.
- Reset outputs: alloc_ready = 1, empty = 1, full = 0, commit_valid = 0, all commit_* = 0, alloc_idx = 0.
- Reset mid-operation discards all content immediately.
- Storage per entry: valid, done, has_dest, dest_arch, p_new, p_old.
- Status: full = (head and tail index bits equal) && (wrap bits differ). empty = pointers fully equal. alloc_ready = !full && !flush. All three are combinational from registered state.
- Allocation occurs on alloc_valid && alloc_ready at the edge:
  - entry[tail] gets valid = 1, done = 0, and the payload fields.
  - tail increments, wrapping modulo ROB_ENTRIES with the wrap bit toggling.
  - alloc_idx = tail index, combinational, valid in the same cycle.
- Destination normalisation: if alloc_has_dest = 0 or alloc_dest_arch = 0, the entry's has_dest is stored as 0. Register 0 never frees a PRN.
- Writeback: wb_valid sets entry[wb_idx].done at the edge.
  - Ignored if that entry is not valid.
  - Repeating a writeback to a done entry has no effect.
- Commit is combinational from the head: commit_valid = entry[head].valid && entry[head].done && !flush.
  - commit_* fields mirror entry[head] while commit_valid = 1 and are 0 otherwise.
  - At the edge with commit_valid = 1: entry[head].valid is cleared and head increments, with wrap.
  - Downstream always accepts; there is no commit back-pressure.
- Latency: a writeback in cycle N makes commit_valid visible in cycle N+1 at the earliest. An allocation in cycle N can complete in cycle N+1 and commit in cycle N+2.
- Simultaneous events in one cycle:
  - Allocation and commit together: count is unchanged.
  - alloc_ready is based on current state only, so allocation is refused when full even if the head commits in the same cycle.
  - A writeback to the head entry in the same cycle as the head is checked does not commit that cycle.
  - A writeback to an entry being allocated the same cycle is impossible: that entry is invalid, so the writeback is ignored.
- Flush has the highest priority:
  - At the edge, head = tail = 0 and all valid/done bits = 0.
  - Allocation, writeback and commit are suppressed in the flush cycle.
- Count: an (IW+1)-bit counter, kept consistent with the pointers. An assertion checks count == tail − head (mod 2·ROB_ENTRIES).

Test Plan:
- Allocate three entries (r1/p32/p1, r2/p33/p2, r3/p34/p3) → alloc_idx 0, 1, 2. Writebacks in order 2, 0, 1 → commits occur in order 0, 1, 2 with commit_p_old 1, 2, 3, one per cycle. The first commit is the cycle after wb_idx = 0.
- Allocate 16 entries with no writeback → full = 1, alloc_ready = 0 at entry 16. A 17th alloc_valid is not accepted. Writeback of idx 0 → commit one cycle later, then alloc_ready = 1.
- Wrap-around: stream 40 allocations, each written back two cycles later → alloc_idx sequence 0..15, 0..15, 0..7. Commits stay in order and no entry is lost.
- Allocation with dest_arch = 0 and has_dest = 1, p_old = 5 → at commit, commit_valid = 1, commit_has_dest = 0, commit_p_old = 0.
- Five entries valid, two done, flush asserted in the same cycle as a writeback and an alloc_valid → commit_valid = 0 in that cycle. Next cycle empty = 1, alloc_idx = 0, and a late writeback to idx 3 has no effect.
- Full ROB with the head done and alloc_valid = 1 → commit occurs and allocation is refused. Next cycle alloc_ready = 1 and the allocation is accepted at idx = old head.
